two_phase_master: RTL and testbench

Clocked initiator for the two-phase req/ack handshake used across the async test library. Accepts one transfer at a time from a synchronous valid/ready port, drives a bundled data word plus a toggling `req`, and retires the transfer when the asynchronous `ack` toggles to match. Sits directly upstream of the two-phase slave responder; `req` and `data_out` feed it, and its `ack` returns here.

---
 rtl/two_phase_pkg.sv | 18 +
 rtl/two_phase_master_sync_ff.sv | 24 ++
 rtl/two_phase_master.sv | 118 +++++++++++
 tb/tb_two_phase_master.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/two_phase_pkg.sv
// Shared types and defaults for the two-phase req/ack handshake blocks.
package two_phase_pkg;

  // Initiator FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2,
    ERROR    = 2'd3
  } state_t;

  // Default parameter values shared by the initiator and its users.
  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_TIMEOUT     = 1023;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage : two_phase_pkg

// File: rtl/two_phase_master_sync_ff.sv
// Reset-to-0 flop chain for bringing a single asynchronous bit into the clk domain.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through STAGES flops; oldest sample is the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule : sync_ff

// File: rtl/two_phase_master.sv
// Clocked initiator for a two-phase req/ack handshake.
//
// Local port handshake: a transfer is accepted on a rising clk edge where
// start && ready are both high; data_in is sampled on that same edge.
// ready depends only on the FSM state, so it never combinationally follows
// start. start while ready is low is dropped, not queued.
//
// Remote side: each req toggle announces one bundled data_out word; the
// transfer retires when the synchronized ack equals req again. data_out is
// held from acceptance until the next accepted start.
//
// Reset drives req low immediately; the responder downstream must be reset
// at the same time or the req/ack phases will disagree afterwards.
import two_phase_pkg::*;

module two_phase_master #(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              req,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack,
  output logic              done,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  txn_count,
  output state_t            state_dbg
);

  // Timeout counter must be able to hold TIMEOUT itself.
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  // Last count value before the timeout fires; comparing against this avoids
  // needing the incremented value in the compare.
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t          state;
  logic [TW-1:0]   tcnt;
  logic            ack_s;
  logic            phase_match;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack),
    .q     (ack_s)
  );

  assign phase_match = (ack_s == req);
  assign ready       = (state == IDLE);
  assign state_dbg   = state;

  // Handshake FSM: all outputs except ready are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req         <= 1'b0;
      data_out    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      txn_count   <= '0;
      tcnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data_out <= data_in;
            state    <= SETUP;
          end
        end

        // One cycle of data setup before the request edge.
        SETUP: begin
          req   <= ~req;
          tcnt  <= '0;
          state <= WAIT_ACK;
        end

        // Retire takes priority over a timeout landing in the same cycle.
        WAIT_ACK: begin
          if (phase_match) begin
            done      <= 1'b1;
            txn_count <= txn_count + 1'b1;
            state     <= IDLE;
          end else if (tcnt == T_LAST) begin
            timeout_err <= 1'b1;
            state       <= ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        // Leave only once the phases agree again, so the next req toggle
        // starts from a consistent handshake; a late ack is not counted.
        ERROR: begin
          if (err_clr && phase_match) begin
            timeout_err <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : two_phase_master

// File: tb/tb_two_phase_master.sv
// Directed bench for two_phase_master: a behavioural responder on the main
// instance, and a second instance with ack wired straight to req for counter
// wrap and minimum-latency checks.
`timescale 1ns/1ps
module tb_two_phase_master;
  import two_phase_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main instance (TIMEOUT=16) ----------------
  logic        start, ready, req, ack, done, timeout_err, err_clr;
  logic [7:0]  data_in, data_out;
  logic [15:0] txn_count;
  state_t      state_dbg;

  two_phase_master #(
    .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(16), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .data_in(data_in),
    .req(req), .data_out(data_out), .ack(ack), .done(done),
    .timeout_err(timeout_err), .err_clr(err_clr), .txn_count(txn_count),
    .state_dbg(state_dbg)
  );

  // ---------------- wrap instance (CNT_W=2, ack looped back) ----------------
  logic        start2, ready2, req2, done2, timeout_err2;
  logic [7:0]  data_in2, data_out2;
  logic [1:0]  txn_count2;
  state_t      state_dbg2;

  two_phase_master #(
    .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(16), .CNT_W(2)
  ) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start2), .ready(ready2), .data_in(data_in2),
    .req(req2), .data_out(data_out2), .ack(req2), .done(done2),
    .timeout_err(timeout_err2), .err_clr(1'b0), .txn_count(txn_count2),
    .state_dbg(state_dbg2)
  );

  // ---------------- responder model ----------------
  logic       slave_en = 1'b1;
  int         slave_dly = 0;
  int         dly_cnt;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack     <= 1'b0;
      dly_cnt <= 0;
    end else if (slave_en && (ack != req)) begin
      if (dly_cnt >= slave_dly) begin
        ack     <= req;
        dly_cnt <= 0;
        rx_q.push_back(data_out);
      end else begin
        dly_cnt <= dly_cnt + 1;
      end
    end else begin
      dly_cnt <= 0;
    end
  end

  // ---------------- monitor: done pulses and req toggles ----------------
  int   done_cnt = 0;
  int   tog_cnt  = 0;
  logic req_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (req !== req_prev) tog_cnt++;
      req_prev = req;
    end
  end

  // ---------------- checking ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_scoreboard(input string tag);
    logic [7:0] got, want;
    chk({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got  = rx_q.pop_front();
      want = exp_q.pop_front();
      chk({tag, "_rx_data"}, 32'(got), 32'(want));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; start2 = 1'b0; err_clr = 1'b0; data_in = '0; data_in2 = '0;
    rst_n = 1'b0;
    tick(); tick();
    done_cnt = 0; tog_cnt = 0;
    rx_q.delete(); exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    bit         seen;
    int         n_acc;
    int         done_seen;
    bit         acc;
    logic [1:0] wrap_exp [5];
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    start = 1'b0; start2 = 1'b0; err_clr = 1'b0; data_in = '0; data_in2 = '0;

    // Reset values, checked while reset is held.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_txn_count", 32'(txn_count), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_ready2", 32'(ready2), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(ready), 32'd1);

    // Single transfer, responder answers a few cycles after req.
    slave_en = 1'b1; slave_dly = 4;
    done_cnt = 0; tog_cnt = 0;
    start = 1'b1; data_in = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    start = 1'b0;
    chk("single_data_setup", 32'(data_out), 32'hA5);
    chk("single_req_before", 32'(req), 32'd0);
    chk("single_ready_busy", 32'(ready), 32'd0);
    tick();
    chk("single_req_edge", 32'(req), 32'd1);
    wait_done(40, seen);
    chk("single_done_seen", 32'(seen), 32'd1);
    chk("single_txn_count", 32'(txn_count), 32'd1);
    tick();
    chk("single_done_pulse", 32'(done), 32'd0);
    chk("single_ready_back", 32'(ready), 32'd1);
    chk("single_done_cnt", 32'(done_cnt), 32'd1);
    chk("single_tog_cnt", 32'(tog_cnt), 32'd1);
    chk_scoreboard("single");

    // Back-to-back transfers with start held high.
    do_reset();
    slave_dly = 0;
    n_acc = 0; done_seen = 0;
    start = 1'b1; data_in = 8'h01;
    for (int i = 0; i < 200 && !(n_acc == 4 && done_seen == 4); i++) begin
      acc = ready && start;
      tick();
      if (done) done_seen++;
      if (acc) begin
        exp_q.push_back(data_in);
        n_acc++;
        data_in = 8'(n_acc + 1);
        if (n_acc == 4) start = 1'b0;
      end
    end
    tick();
    chk("b2b_accepted", 32'(n_acc), 32'd4);
    chk("b2b_done_seen", 32'(done_seen), 32'd4);
    chk("b2b_tog_cnt", 32'(tog_cnt), 32'd4);
    chk("b2b_req_final", 32'(req), 32'd0);
    chk("b2b_txn_count", 32'(txn_count), 32'd4);
    chk("b2b_ready", 32'(ready), 32'd1);
    chk_scoreboard("b2b");

    // Reset in WAIT_ACK after earlier traffic.
    slave_dly = 20;
    start = 1'b1; data_in = 8'h77;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("midrst_pre_state", 32'(state_dbg), 32'(WAIT_ACK));
    chk("midrst_pre_req", 32'(req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(req), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_txn_count", 32'(txn_count), 32'd0);
    chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_after_ready", 32'(ready), 32'd1);
    chk("midrst_after_state", 32'(state_dbg), 32'(IDLE));

    // start during WAIT_ACK is dropped.
    do_reset();
    slave_dly = 8;
    start = 1'b1; data_in = 8'h3C;
    exp_q.push_back(8'h3C);
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; data_in = 8'hFF;
    tick();
    start = 1'b0;
    chk("ign_data_out", 32'(data_out), 32'h3C);
    chk("ign_state", 32'(state_dbg), 32'(WAIT_ACK));
    wait_done(40, seen);
    chk("ign_done_seen", 32'(seen), 32'd1);
    tick();
    chk("ign_tog_cnt", 32'(tog_cnt), 32'd1);
    chk("ign_done_cnt", 32'(done_cnt), 32'd1);
    chk("ign_data_hold", 32'(data_out), 32'h3C);
    chk("ign_txn_count", 32'(txn_count), 32'd1);
    chk_scoreboard("ign");

    // Timeout with the responder disconnected.
    do_reset();
    slave_en = 1'b0;
    start = 1'b1; data_in = 8'h5A;
    tick();
    start = 1'b0;
    tick();
    repeat (15) tick();
    chk("to_last_wait_state", 32'(state_dbg), 32'(WAIT_ACK));
    chk("to_last_wait_err", 32'(timeout_err), 32'd0);
    tick();
    chk("to_state", 32'(state_dbg), 32'(ERROR));
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_ready", 32'(ready), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clr_mismatch_state", 32'(state_dbg), 32'(ERROR));
    chk("to_clr_mismatch_err", 32'(timeout_err), 32'd1);
    slave_en = 1'b1; slave_dly = 0;
    repeat (5) tick();
    chk("to_late_ack_state", 32'(state_dbg), 32'(ERROR));
    chk("to_late_ack_done_cnt", 32'(done_cnt), 32'd0);
    chk("to_late_ack_txn", 32'(txn_count), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clr_state", 32'(state_dbg), 32'(IDLE));
    chk("to_clr_err", 32'(timeout_err), 32'd0);
    chk("to_clr_ready", 32'(ready), 32'd1);
    chk("to_clr_txn", 32'(txn_count), 32'd0);
    chk("to_clr_data_out", 32'(data_out), 32'h5A);
    chk("to_clr_req", 32'(req), 32'd1);

    // Second timeout, then reset clears the sticky error.
    slave_en = 1'b0;
    start = 1'b1; data_in = 8'h6B;
    tick();
    start = 1'b0;
    repeat (17) tick();
    chk("to2_state", 32'(state_dbg), 32'(ERROR));
    chk("to2_err", 32'(timeout_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("to2_rst_err", 32'(timeout_err), 32'd0);
    chk("to2_rst_ready", 32'(ready), 32'd1);
    tick();
    rst_n = 1'b1;
    slave_en = 1'b1;
    tick();

    // Counter wrap and minimum latency with ack looped back.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      chk("wrap_ready_before", 32'(ready2), 32'd1);
      start2 = 1'b1; data_in2 = 8'(k);
      tick();
      start2 = 1'b0;
      repeat (3) tick();
      chk("wrap_done_early", 32'(done2), 32'd0);
      tick();
      chk("wrap_done", 32'(done2), 32'd1);
      chk("wrap_ready", 32'(ready2), 32'd1);
      chk("wrap_txn_count", 32'(txn_count2), 32'(wrap_exp[k]));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_two_phase_master
